// File: rtl/seq_divider.sv
// seq_divider -- multi-cycle restoring integer divider.
//
// One trial subtraction per clock: WIDTH CALC cycles produce quotient and
// remainder of dividend / divisor. Start/done handshake, one op at a time.
//
// Ports:
//   clk, rst_n           rising-edge clock, asynchronous active-low reset
//   start                request, sampled only while idle
//   dividend, divisor    operands, sampled with an accepted start
//   busy                 high from the accept edge until the DONE cycle ends
//   done                 one-cycle pulse, results valid
//   quotient, remainder  results, held until the next accepted start
//   div_by_zero          divisor was 0 (quotient = all ones, remainder = dividend)
//
// Optional feature: define DIVIDER_SIGNED_EN for two's-complement operands
// (quotient truncates toward zero, remainder takes the dividend's sign).
// Without it the divider is purely unsigned and has no sign logic.
module seq_divider #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state;
  logic [CW-1:0]    count;
  // After every restore the partial remainder is below M, so it fits in
  // WIDTH bits; the WIDTH+1-bit trial value below carries the extra bit.
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] m;
  logic             dz;       // zero divisor: finish after a single CALC cycle

  logic [WIDTH-1:0] dvd_mag, dvs_mag;
  logic [WIDTH:0]   a_sh, a_diff;
  logic [WIDTH-1:0] a_nxt, q_nxt;
  logic [WIDTH-1:0] q_res, r_res, r_src;

  // Operand magnitudes fed to the unsigned core
`ifdef DIVIDER_SIGNED_EN
  logic neg_q, neg_r;
  assign dvd_mag = dividend[WIDTH-1] ? -dividend : dividend;
  assign dvs_mag = divisor[WIDTH-1]  ? -divisor  : divisor;
`else
  assign dvd_mag = dividend;
  assign dvs_mag = divisor;
`endif

  // One restoring step: shift {A,Q} left, trial-subtract M, keep or restore.
  always_comb begin
    a_sh   = {a, q[WIDTH-1]};
    a_diff = a_sh - {1'b0, m};
    q_nxt  = {q[WIDTH-2:0], ~a_diff[WIDTH]};
    a_nxt  = a_diff[WIDTH] ? a_sh[WIDTH-1:0] : a_diff[WIDTH-1:0];
  end

  // Final results; for a zero divisor Q still holds the dividend magnitude.
  always_comb begin
    r_src = dz ? q : a_nxt;
`ifdef DIVIDER_SIGNED_EN
    q_res = dz ? '1 : (neg_q ? -q_nxt : q_nxt);
    r_res = neg_r ? -r_src : r_src;
`else
    q_res = dz ? '1 : q_nxt;
    r_res = r_src;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      count       <= '0;
      a           <= '0;
      q           <= '0;
      m           <= '0;
      dz          <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          busy <= 1'b0;
          if (start) begin
            busy        <= 1'b1;
            div_by_zero <= 1'b0;
            a           <= '0;
            q           <= dvd_mag;
            m           <= dvs_mag;
            state       <= CALC;
`ifdef DIVIDER_SIGNED_EN
            neg_q       <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            neg_r       <= dividend[WIDTH-1];
`endif
            // Zero divisor takes one CALC cycle so done rises one clock
            // after acceptance instead of WIDTH.
            if (divisor == '0) begin
              dz    <= 1'b1;
              count <= CW'(1);
            end else begin
              dz    <= 1'b0;
              count <= CW'(WIDTH);
            end
          end
        end
        CALC: begin
          count <= count - 1'b1;
          if (!dz) begin
            a <= a_nxt;
            q <= q_nxt;
          end
          if (count == CW'(1)) begin
            quotient    <= q_res;
            remainder   <= r_res;
            div_by_zero <= dz;
            done        <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed cases plus random operands
// against an arithmetic reference model. Honours DIVIDER_SIGNED_EN.
module tb_seq_divider;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy, done, div_by_zero;
  logic [W-1:0] quotient, remainder;

  int n_cmp = 0;
  int n_bad = 0;

  seq_divider #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend),
    .divisor(divisor), .busy(busy), .done(done), .quotient(quotient),
    .remainder(remainder), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Reference: plain integer division
  task automatic model(input logic [W-1:0] d, input logic [W-1:0] v,
                       output logic [W-1:0] q, output logic [W-1:0] r, output logic z);
`ifdef DIVIDER_SIGNED_EN
    int sd, sv;
    sd = $signed(d);
    sv = $signed(v);
    if (sv == 0) begin q = '1; r = d; z = 1'b1; end
    else begin q = W'(sd / sv); r = W'(sd % sv); z = 1'b0; end
`else
    int ud, uv;
    ud = int'(d);
    uv = int'(v);
    if (uv == 0) begin q = '1; r = d; z = 1'b1; end
    else begin q = W'(ud / uv); r = W'(ud % uv); z = 1'b0; end
`endif
  endtask

  // Issue one op; inj >= 0 pulses a competing start (8/2) at that cycle.
  task automatic run_op(input logic [W-1:0] d, input logic [W-1:0] v,
                        input int inj, input string nm);
    logic [W-1:0] eq, er, gq, gr;
    logic         ez, gz;
    int           busy_n, done_n, done_k, lat;
    model(d, v, eq, er, ez);
    @(negedge clk);
    dividend = d; divisor = v; start = 1'b1;
    @(negedge clk);
    start = 1'b0; dividend = W'($urandom); divisor = W'($urandom);
    busy_n = 0; done_n = 0; done_k = -1; gq = '0; gr = '0; gz = 1'b0;
    for (int k = 0; k < 4*W + 8; k++) begin
      if (k == inj) begin start = 1'b1; dividend = W'(8); divisor = W'(2); end
      else if (k == inj + 1) start = 1'b0;
      if (busy) busy_n++;
      if (done) begin
        done_n++;
        if (done_k < 0) begin done_k = k; gq = quotient; gr = remainder; gz = div_by_zero; end
      end
      if (!busy && k > 0) break;
      @(negedge clk);
    end
    start = 1'b0;
    lat = (v == '0) ? 1 : W;
    chk({nm, ".lat"},   done_k, lat);
    chk({nm, ".busy"},  busy_n, lat + 1);
    chk({nm, ".ndone"}, done_n, 1);
    chk({nm, ".q"},     gq, eq);
    chk({nm, ".r"},     gr, er);
    chk({nm, ".dz"},    gz, ez);
    chk({nm, ".qhold"}, quotient, eq);
    chk({nm, ".rhold"}, remainder, er);
  endtask

  initial begin
    logic [W-1:0] rd, rv;
    int nd;
    repeat (3) @(negedge clk);
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    chk("rst.q",    quotient, 0);
    chk("rst.r",    remainder, 0);
    chk("rst.dz",   div_by_zero, 0);
    rst_n = 1'b1;

    run_op(W'(13), W'(3), -1, "13/3");
    run_op(W'(15), W'(1), -1, "15/1");
    run_op(W'(3),  W'(7), -1, "3/7");
    run_op(W'(9),  W'(0), -1, "9/0");
    run_op(W'(6),  W'(2), -1, "6/2");
    run_op(W'(13), W'(3), 1,  "ign");

`ifndef DIVIDER_SIGNED_EN
    // Literal results for the unsigned build
    run_op(W'(13), W'(3), -1, "lit");
    chk("lit.q13_3", quotient, 4);
    chk("lit.r13_3", remainder, 1);
`endif

    // Reset in the middle of CALC abandons the op with no done pulse
    @(negedge clk);
    dividend = W'(13); divisor = W'(3); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid.busy", busy, 0);
    chk("mid.done", done, 0);
    chk("mid.q",    quotient, 0);
    chk("mid.r",    remainder, 0);
    chk("mid.dz",   div_by_zero, 0);
    nd = 0;
    repeat (2) begin @(negedge clk); if (done) nd++; end
    rst_n = 1'b1;
    repeat (W + 2) begin @(negedge clk); if (done) nd++; end
    chk("mid.nodone", nd, 0);
    run_op(W'(10), W'(4), -1, "10/4");

`ifdef DIVIDER_SIGNED_EN
    run_op(4'b1001, 4'b0010, -1, "s-7/2");
    chk("s.q-7_2", quotient, 4'b1101);
    chk("s.r-7_2", remainder, 4'b1111);
    run_op(4'b0111, 4'b1110, -1, "s7/-2");
    chk("s.q7_-2", quotient, 4'b1101);
    chk("s.r7_-2", remainder, 4'b0001);
    run_op(4'b1000, 4'b1111, -1, "s-8/-1");
    chk("s.q-8_-1", quotient, 4'b1000);
    chk("s.r-8_-1", remainder, 4'b0000);
    chk("s.dz-8_-1", div_by_zero, 0);
`endif

    for (int i = 0; i < 40; i++) begin
      rd = W'($urandom);
      rv = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      run_op(rd, rv, -1, "rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
